// File: rtl/core_of_top.sv
// Sensor alarm controller: periodically requests an LM75A temperature read,
// samples the ultrasonic distance every cycle and drives a buzzer on either alarm.
module core_of_top #(
  parameter int unsigned SAMPLE_INTERVAL = 50,
  parameter int unsigned REQ_TIMEOUT     = 100,
  parameter int unsigned TEMP_HI         = 38,
  parameter int unsigned DIST_LO         = 50
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Read_temp_ok,
  input  logic [10:0] Temp_data,
  input  logic [15:0] CSB_data,
  output logic        LM75A_EN,
  output logic        BUZZER_EN
);

  localparam int unsigned CNT_MAX = (SAMPLE_INTERVAL > REQ_TIMEOUT) ? SAMPLE_INTERVAL : REQ_TIMEOUT;
  localparam int CNT_W = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               capture;
  logic [10:0]        temp_reg;
  logic [15:0]        dist_reg;
  logic               temp_alarm, dist_alarm;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    next_state = state;
    cnt_next   = cnt + CNT_W'(1);
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        // One full cycle in IDLE after the reset cycle, so the first request lands on the 2nd edge.
        if (cnt == CNT_W'(1)) begin
          next_state = REQ;
          cnt_next   = '0;
        end
      end
      REQ: begin
        if (Read_temp_ok) begin
          capture    = 1'b1;
          next_state = WAIT;
          cnt_next   = '0;
        end else if (cnt == CNT_W'(REQ_TIMEOUT - 1)) begin
          next_state = WAIT;
          cnt_next   = '0;
        end
      end
      WAIT: begin
        if (cnt == CNT_W'(SAMPLE_INTERVAL - 1)) begin
          next_state = REQ;
          cnt_next   = '0;
        end
      end
      default: begin
        next_state = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign temp_alarm = (temp_reg >= 11'(TEMP_HI));
  assign dist_alarm = (dist_reg != 16'd0) && (dist_reg < 16'(DIST_LO));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      temp_reg  <= '0;
      dist_reg  <= '0;
      LM75A_EN  <= 1'b0;
      BUZZER_EN <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
      state     <= next_state;
      cnt       <= cnt_next;
      dist_reg  <= CSB_data;
      LM75A_EN  <= (next_state == REQ);
      BUZZER_EN <= temp_alarm | dist_alarm;
      if (capture) temp_reg <= Temp_data;
    end
  end

endmodule

// File: tb/tb_core_of_top.sv
// Directed self-checking bench for core_of_top: reset, temperature, distance,
// combined, boundary, timeout and mid-operation reset scenarios.
module tb_core_of_top;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Read_temp_ok;
  logic [10:0] Temp_data;
  logic [15:0] CSB_data;
  logic        LM75A_EN;
  logic        BUZZER_EN;

  int tests  = 0;
  int failed = 0;

  core_of_top dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .Read_temp_ok (Read_temp_ok),
    .Temp_data    (Temp_data),
    .CSB_data     (CSB_data),
    .LM75A_EN     (LM75A_EN),
    .BUZZER_EN    (BUZZER_EN)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_en(input string tag, input logic level);
    int n = 0;
    while (LM75A_EN !== level && n < 300) begin
      tick();
      n++;
    end
    check(tag, LM75A_EN, level);
  endtask

  // Capture one temperature with Read_temp_ok high; buzzer holds its old value
  // across the capture edge and takes the new value on the following edge.
  task automatic capture(input string tag, input logic [10:0] temp,
                         input logic buz_before, input logic buz_after);
    Temp_data = temp;
    wait_en({tag, "_req"}, 1'b1);
    tick();
    check({tag, "_en_off"}, LM75A_EN, 1'b0);
    check({tag, "_buz_hold"}, BUZZER_EN, buz_before);
    tick();
    check({tag, "_buz"}, BUZZER_EN, buz_after);
  endtask

  task automatic set_dist(input string tag, input logic [15:0] d, input logic buz);
    CSB_data = d;
    tick();
    tick();
    check(tag, BUZZER_EN, buz);
  endtask

  initial begin
    int hi;
    int lo;
    Rst_n        = 1'b0;
    Read_temp_ok = 1'b1;
    Temp_data    = 11'd40;
    CSB_data     = 16'd30;

    // Reset held with alarm-level inputs: outputs stay low throughout.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_en", LM75A_EN, 1'b0);
      check("rst_buz", BUZZER_EN, 1'b0);
    end
    Temp_data = 11'd35;
    CSB_data  = 16'd0;
    Rst_n     = 1'b1;
    tick();
    check("rel_edge1_en", LM75A_EN, 1'b0);
    tick();
    check("rel_edge2_en", LM75A_EN, 1'b1);

    // Temperature scenario.
    capture("t35", 11'd35, 1'b0, 1'b0);
    capture("t40", 11'd40, 1'b0, 1'b1);

    // Distance scenario.
    CSB_data = 16'd100;
    capture("d_t35", 11'd35, 1'b1, 1'b0);
    set_dist("d30", 16'd30, 1'b1);
    set_dist("d0", 16'd0, 1'b0);

    // Combined scenario.
    CSB_data = 16'd30;
    capture("c_t40", 11'd40, 1'b1, 1'b1);
    capture("c_t20", 11'd20, 1'b1, 1'b1);
    set_dist("c_d100", 16'd100, 1'b0);

    // Boundary scenario.
    capture("b_t37", 11'd37, 1'b0, 1'b0);
    capture("b_t38", 11'd38, 1'b0, 1'b1);
    capture("b_t20", 11'd20, 1'b1, 1'b0);
    set_dist("b_d50", 16'd50, 1'b0);
    set_dist("b_d49", 16'd49, 1'b1);
    set_dist("b_d100", 16'd100, 1'b0);

    // Timeout scenario; an ok pulse during WAIT must be ignored.
    Read_temp_ok = 1'b0;
    Temp_data    = 11'd99;
    wait_en("to_low", 1'b0);
    wait_en("to_high", 1'b1);
    hi = 0;
    while (LM75A_EN === 1'b1 && hi < 300) begin
      hi++;
      tick();
    end
    check("to_hi_cycles", hi, 100);
    lo = 0;
    while (LM75A_EN === 1'b0 && lo < 300) begin
      Read_temp_ok = (lo < 10);
      lo++;
      tick();
    end
    Read_temp_ok = 1'b0;
    check("to_lo_cycles", lo, 50);
    check("to_en_again", LM75A_EN, 1'b1);
    tick();
    check("to_temp_kept", BUZZER_EN, 1'b0);

    // Asynchronous reset mid-REQ with buzzer active.
    set_dist("m_d30", 16'd30, 1'b1);
    check("m_in_req", LM75A_EN, 1'b1);
    #2;
    Rst_n = 1'b0;
    #1;
    check("m_async_en", LM75A_EN, 1'b0);
    check("m_async_buz", BUZZER_EN, 1'b0);
    tick();
    tick();
    check("m_hold_buz", BUZZER_EN, 1'b0);
    Read_temp_ok = 1'b1;
    Temp_data    = 11'd35;
    CSB_data     = 16'd0;
    Rst_n        = 1'b1;
    tick();
    check("m_edge1_en", LM75A_EN, 1'b0);
    tick();
    check("m_edge2_en", LM75A_EN, 1'b1);
    tick();
    check("m_en_off", LM75A_EN, 1'b0);
    check("m_buz", BUZZER_EN, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/core_of_top.md
CORE_OF_TOP -- requirements
Module: core_of_top

Interface
REQ-001 Parameter SAMPLE_INTERVAL, default 50: clock cycles spent in WAIT between temperature requests.
REQ-002 Parameter REQ_TIMEOUT, default 100: maximum cycles in REQ before the request is abandoned.
REQ-003 Parameter TEMP_HI, default 38: temperature alarm threshold, same units as Temp_data (integer degC).
REQ-004 Parameter DIST_LO, default 50: distance alarm threshold, same units as CSB_data (cm).
REQ-005 Clk  input  1: single system clock; all state updates on its rising edge.
REQ-006 Rst_n  input  1: asynchronous, active-low reset.
REQ-007 Read_temp_ok  input  1: level, high when the LM75A reader has valid data on Temp_data.
REQ-008 Temp_data  input  11: unsigned temperature, integer degC.
REQ-009 CSB_data  input  16: unsigned ultrasonic distance in cm; 0 means no valid echo.
REQ-010 LM75A_EN  output  1: registered; high requests a temperature read from the LM75A reader.
REQ-011 BUZZER_EN  output  1: registered; high drives the buzzer.

Function
REQ-012 Controller FSM SHALL have three states: IDLE, REQ, WAIT.
REQ-013 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-014 LM75A_EN SHALL be 1 exactly while the FSM is in REQ, and 0 in IDLE and WAIT.
REQ-015 In REQ with Read_temp_ok=1 at a rising edge, the block SHALL capture Temp_data into temp_reg, then go to WAIT.
REQ-016 In REQ, if Read_temp_ok stays 0 for REQ_TIMEOUT consecutive cycles, the FSM SHALL go to WAIT and temp_reg SHALL keep its old value.
REQ-017 WAIT SHALL last exactly SAMPLE_INTERVAL cycles, then go to REQ.
REQ-018 The WAIT/timeout counter SHALL clear on every state entry.
REQ-019 Read_temp_ok held continuously high SHALL complete each REQ in one cycle.
REQ-020 Read_temp_ok SHALL be ignored outside REQ.
REQ-021 CSB_data SHALL be registered into dist_reg every cycle, with no handshake.
REQ-022 temp_alarm SHALL be (temp_reg >= TEMP_HI), an unsigned 11-bit compare.
REQ-023 dist_alarm SHALL be (dist_reg != 0) AND (dist_reg < DIST_LO), an unsigned 16-bit compare.
REQ-024 BUZZER_EN SHALL be registered as temp_alarm OR dist_alarm, with no hysteresis.
REQ-025 BUZZER_EN SHALL update on the edge after a temp_reg capture, and within 2 cycles of a CSB_data change.
REQ-026 Simultaneous temperature and distance alarms SHALL give BUZZER_EN=1; clearing one alarm SHALL not drop BUZZER_EN while the other persists.
REQ-027 Boundaries: temperature 37 gives no alarm and 38 gives alarm; distance 49 gives alarm, 50 gives none, and 0 gives none.

Reset
REQ-028 Rst_n=0 SHALL immediately, without waiting for Clk, force: state=IDLE, counter=0, temp_reg=0, dist_reg=0, LM75A_EN=0, BUZZER_EN=0.
REQ-029 Reset asserted mid-REQ or mid-WAIT SHALL abort the operation.
REQ-030 After reset release, the sequence SHALL restart from IDLE.
REQ-031 No output SHALL glitch high during reset.

Verification
REQ-032 Reset scenario: Rst_n=0 for 10 cycles with Read_temp_ok=1 -> LM75A_EN=0 and BUZZER_EN=0 throughout; after release LM75A_EN rises on the 2nd edge.
REQ-033 Temperature scenario: Read_temp_ok=1, Temp_data=35, CSB_data=0 -> BUZZER_EN=0; Temp_data=40 -> BUZZER_EN=1 one cycle after the next capture.
REQ-034 Distance scenario: Temp_data=35, CSB_data=100 -> BUZZER_EN=0; CSB_data=30 -> BUZZER_EN=1 within 2 cycles; CSB_data=0 -> BUZZER_EN=0.
REQ-035 Combined scenario: Temp_data=40, CSB_data=30 -> BUZZER_EN=1; Temp_data=20 with CSB_data=30 -> BUZZER_EN stays 1; CSB_data=100 -> BUZZER_EN=0.
REQ-036 Timeout scenario: Read_temp_ok=0 -> LM75A_EN high for exactly 100 cycles, low for 50, then high again; temp_reg unchanged.
REQ-037 Boundary scenario: Temp_data 37 then 38 -> BUZZER_EN 0 then 1; CSB_data 50 then 49 -> BUZZER_EN 0 then 1.
